vid_is_stream_arbiter: RTL

Two-input Avalon-ST video packet arbiter that shares a single Avalon-ST video output between two clocked-video input streams. It grants the output per packet, and locks a control packet to the video packet that follows it so a frame's header and its pixels always leave together. It sits between two Vid2IS output stages and the downstream VIP pipeline, and reports per-input frame counts for software.

---
 rtl/vid_is_stream_arbiter_if.sv | 19 +
 rtl/vid_is_stream_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vid_is_stream_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : vid_is_stream_arbiter_if
// Purpose  : Avalon-ST video beat bundle (data, valid, sop, eop, ready).
// Revision : 1.0
// ============================================================================
interface vid_is_stream_arbiter_if #(
  parameter int DATA_WIDTH = 20
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  sop;
  logic                  eop;
  logic                  ready;

  modport master (output data, output valid, output sop, output eop, input ready);
  modport slave  (input data, input valid, input sop, input eop, output ready);
endinterface
`default_nettype wire

// File: rtl/vid_is_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vid_is_stream_arbiter
// Purpose  : Two-input per-packet video arbiter; a control packet stays locked
//            to the video packet that follows it on the same input.
// Revision : 1.0
// ============================================================================
module vid_is_stream_arbiter #(
  parameter int DATA_WIDTH        = 20,
  parameter int FRAME_COUNT_WIDTH = 16
) (
  input  logic                         is_clk,
  input  logic                         rst_n,
  input  logic [1:0]                   en,
  vid_is_stream_arbiter_if.slave       in0,
  vid_is_stream_arbiter_if.slave       in1,
  vid_is_stream_arbiter_if.master      out,
  output logic                         active_input,
  output logic                         busy,
  output logic [FRAME_COUNT_WIDTH-1:0] frame_count0,
  output logic [FRAME_COUNT_WIDTH-1:0] frame_count1
);

  localparam logic [3:0] c_ptype_video = 4'd0;
  localparam logic [3:0] c_ptype_ctrl  = 4'd15;
  localparam logic [FRAME_COUNT_WIDTH-1:0] c_fc_one = {{(FRAME_COUNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PASS_FIRST = 3'd1,
    ST_PASS_CTRL  = 3'd2,
    ST_PASS_OTHER = 3'd3,
    ST_WAIT_VIDEO = 3'd4,
    ST_PASS_VIDEO = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic                   grant_q, grant_d;
  logic                   last_grant_q, last_grant_d;
  logic                   lock_q, lock_d;
  logic                   busy_q, busy_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_sop_q, out_sop_d;
  logic                   out_eop_q, out_eop_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic [FRAME_COUNT_WIDTH-1:0] frame_count0_q, frame_count0_d;
  logic [FRAME_COUNT_WIDTH-1:0] frame_count1_q, frame_count1_d;

  logic [1:0]            w_valid;
  logic [1:0]            w_sop;
  logic [1:0]            w_eop;
  logic [1:0]            w_req;
  logic [1:0]            w_ready;
  logic                  w_load_ok;
  logic                  w_pass;
  logic                  w_xfer;
  logic                  w_g_valid;
  logic                  w_g_sop;
  logic                  w_g_eop;
  logic                  w_pick;
  logic                  w_video_done;
  logic [DATA_WIDTH-1:0] w_g_data;
  logic [3:0]            w_g_ptype;

  assign w_valid   = {in1.valid, in0.valid};
  assign w_sop     = {in1.sop, in0.sop};
  assign w_eop     = {in1.eop, in0.eop};
  assign w_g_valid = w_valid[grant_q];
  assign w_g_sop   = w_sop[grant_q];
  assign w_g_eop   = w_eop[grant_q];
  assign w_g_data  = grant_q ? in1.data : in0.data;
  assign w_g_ptype = w_g_data[3:0];

  assign w_load_ok = ~out_valid_q | out.ready;
  assign w_pass    = state_q inside {ST_PASS_FIRST, ST_PASS_CTRL, ST_PASS_OTHER, ST_PASS_VIDEO};
  assign w_xfer    = w_pass & w_g_valid & w_load_ok;

  // Round-robin on a tie: the input that did not win last time goes first.
  assign w_req  = en & w_valid & w_sop;
  assign w_pick = (w_req == 2'b11) ? ~last_grant_q : w_req[1];

  assign w_video_done = w_xfer & w_g_eop &
                        (((state_q == ST_PASS_FIRST) && (w_g_ptype == c_ptype_video)) ||
                         (state_q == ST_PASS_VIDEO));

  // Beats without sop outside a packet are swallowed so they cannot stall an input.
  always_comb begin
    w_ready = 2'b00;
    if (w_pass) begin
      w_ready[grant_q] = w_load_ok;
    end else if (state_q == ST_IDLE) begin
      w_ready = en & w_valid & ~w_sop;
    end else if (state_q == ST_WAIT_VIDEO) begin
      w_ready[grant_q] = w_g_valid & ~w_g_sop;
    end
  end

  assign in0.ready = w_ready[0];
  assign in1.ready = w_ready[1];

  always_comb begin
    out_valid_d = out_valid_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_data_d  = out_data_q;
    if (w_load_ok) begin
      out_valid_d = w_xfer;
      out_sop_d   = w_xfer & w_g_sop;
      out_eop_d   = w_xfer & w_g_eop;
      if (w_xfer) begin
        out_data_d = w_g_data;
      end
    end
  end

  always_comb begin
    frame_count0_d = frame_count0_q;
    frame_count1_d = frame_count1_q;
    if (w_video_done) begin
      if (grant_q) begin
        frame_count1_d = frame_count1_q + c_fc_one;
      end else begin
        frame_count0_d = frame_count0_q + c_fc_one;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    lock_d       = lock_q;
    case (state_q)
      ST_IDLE: begin
        lock_d = 1'b0;
        if (|w_req) begin
          grant_d      = w_pick;
          last_grant_d = w_pick;
          state_d      = ST_PASS_FIRST;
        end
      end
      ST_PASS_FIRST: begin
        if (w_xfer) begin
          if (w_g_eop) begin
            if (w_g_ptype == c_ptype_ctrl) begin
              lock_d  = 1'b1;
              state_d = ST_WAIT_VIDEO;
            end else begin
              lock_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end else if (w_g_ptype == c_ptype_ctrl) begin
            lock_d  = 1'b1;
            state_d = ST_PASS_CTRL;
          end else if (w_g_ptype == c_ptype_video) begin
            state_d = ST_PASS_VIDEO;
          end else begin
            state_d = ST_PASS_OTHER;
          end
        end
      end
      ST_PASS_CTRL: begin
        if (w_xfer && w_g_eop) begin
          state_d = ST_WAIT_VIDEO;
        end
      end
      ST_PASS_OTHER: begin
        if (w_xfer && w_g_eop) begin
          state_d = lock_q ? ST_WAIT_VIDEO : ST_IDLE;
        end
      end
      ST_WAIT_VIDEO: begin
        if (w_g_valid && w_g_sop) begin
          state_d = ST_PASS_FIRST;
        end
      end
      ST_PASS_VIDEO: begin
        if (w_xfer && w_g_eop) begin
          lock_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        lock_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy_d = (state_d != ST_IDLE);

  always_ff @(posedge is_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      grant_q        <= 1'b0;
      last_grant_q   <= 1'b1;
      lock_q         <= 1'b0;
      busy_q         <= 1'b0;
      out_valid_q    <= 1'b0;
      out_sop_q      <= 1'b0;
      out_eop_q      <= 1'b0;
      out_data_q     <= '0;
      frame_count0_q <= '0;
      frame_count1_q <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      last_grant_q   <= last_grant_d;
      lock_q         <= lock_d;
      busy_q         <= busy_d;
      out_valid_q    <= out_valid_d;
      out_sop_q      <= out_sop_d;
      out_eop_q      <= out_eop_d;
      out_data_q     <= out_data_d;
      frame_count0_q <= frame_count0_d;
      frame_count1_q <= frame_count1_d;
    end
  end

  assign out.valid    = out_valid_q;
  assign out.sop      = out_sop_q;
  assign out.eop      = out_eop_q;
  assign out.data     = out_data_q;
  assign active_input = last_grant_q;
  assign busy         = busy_q;
  assign frame_count0 = frame_count0_q;
  assign frame_count1 = frame_count1_q;

endmodule
`default_nettype wire
